uart_rx_os16: RTL and testbench

16x-oversampling receiver for the 9N1 serial link (9 data bits, LSB first, no parity, 1 stop bit, line idles high). Synchronizes the asynchronous `rx` line, locates each bit centre by majority vote, and presents each received word through a one-entry valid/ready holding register. It sits at the input side of the design, facing an external 9N1 transmitter. Framing errors and overruns are reported as one-cycle pulses.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync.sv | 24 ++
 rtl/uart_rx_os16.sv | 149 ++++++++++++++
 tb/tb_uart_rx_os16.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared 9N1 serial constants, receiver state enum and vote helper
package uart_pkg;

  localparam int DATA_BITS  = 9;
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  // 2-of-3 majority used to reject single-sample noise around a bit centre
  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer for a single asynchronous input
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // first flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x oversampling 9N1 receiver with one-entry valid/ready holding register
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = 27
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 framing_error,
  output logic                 overrun
);

  localparam int DIV_W  = $clog2(CLKS_PER_SAMPLE);
  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam int IDX_W  = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLKS_PER_SAMPLE - 1);
  localparam logic [SAMP_W-1:0] S_FIRST  = SAMP_W'(SAMPLE_MID - 1);
  localparam logic [SAMP_W-1:0] S_MID    = SAMP_W'(SAMPLE_MID);
  localparam logic [SAMP_W-1:0] S_LAST   = SAMP_W'(SAMPLE_MID + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_BITS - 1);

  rx_state_t            state, state_nxt;
  logic                 rxs;
  logic [DIV_W-1:0]     div_cnt;
  logic [SAMP_W-1:0]    samp_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [1:0]           vote_q;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick;
  logic                 at_decide;
  logic                 vote;
  logic                 shift_en;
  logic                 commit;
  logic                 frame_bad;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rxs)
  );

  // tick is suppressed in IDLE so the divider phase is set by the start edge
  assign tick      = (state != RX_IDLE) && (div_cnt == DIV_LAST);
  assign at_decide = tick && (samp_cnt == S_LAST);
  assign vote      = majority3({vote_q, rxs});

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_nxt;
  end

  // next-state and per-cycle strobes; the free-running sample counter wraps
  // 15->0 between START and DATA so bit centres stay 16 samples apart
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    commit    = 1'b0;
    frame_bad = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rxs) state_nxt = RX_START;
      end
      RX_START: begin
        if (at_decide) state_nxt = vote ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (at_decide) begin
          shift_en = 1'b1;
          if (bit_idx == IDX_LAST) state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (at_decide) begin
          if (vote) begin
            commit    = 1'b1;
            state_nxt = RX_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nxt = RX_WAIT_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: begin
        if (rxs) state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  // divider, sample counter and bit index; all held cleared while idle
  always_ff @(posedge clock) begin
    if (reset || state == RX_IDLE) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick)     samp_cnt <= samp_cnt + 1'b1;
      if (shift_en) bit_idx  <= bit_idx + 1'b1;
    end
  end

  // latch the two samples ahead of the centre; the third is taken live
  always_ff @(posedge clock) begin
    if (reset) begin
      vote_q <= 2'b11;
    end else begin
      if (tick && samp_cnt == S_FIRST) vote_q[1] <= rxs;
      if (tick && samp_cnt == S_MID)   vote_q[0] <= rxs;
    end
  end

  // LSB-first shift register: newest bit enters at the top
  always_ff @(posedge clock) begin
    if (reset)         shreg <= '0;
    else if (shift_en) shreg <= {vote, shreg[DATA_BITS-1:1]};
  end

  // holding register plus one-cycle error pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      data          <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= frame_bad;
      overrun       <= 1'b0;
      if (commit) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb/tb_uart_rx_os16.sv - scoreboard bench driving behavioural 9N1 frames into uart_rx_os16
module tb_uart_rx_os16;

  localparam int CPS = 4;
  localparam int BIT = 16 * CPS;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic [8:0] data;
  logic       valid;
  logic       framing_error;
  logic       overrun;

  int         checks   = 0;
  int         errors   = 0;
  int         rx_words = 0;
  int         fe_cnt   = 0;
  int         ov_cnt   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  always #5 clock = ~clock;

  uart_rx_os16 #(.CLKS_PER_SAMPLE(CPS)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .data          (data),
    .valid         (valid),
    .ready         (ready),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: pops the scoreboard on every accepted word, counts error pulses
  always @(negedge clock) begin
    if (!reset) begin
      if (valid && ready) begin
        rx_words++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("word", int'(data), int'(mon_exp));
        end
      end
      if (framing_error) fe_cnt++;
      if (overrun)       ov_cnt++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    cycles(BIT);
  endtask

  task automatic send_frame(input logic [8:0] w, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 9; i++) drive_bit(w[i]);
    drive_bit(stop_bit);
    rx = 1'b1;
  endtask

  initial begin
    cycles(5);
    reset = 1'b0;
    cycles(200);
    check("reset_valid", int'(valid), 0);
    check("reset_data", int'(data), 'h000);
    check("reset_fe", fe_cnt, 0);
    check("reset_ov", ov_cnt, 0);

    ready = 1'b1;
    exp_q.push_back(9'h0D5);
    exp_q.push_back(9'h12A);
    send_frame(9'h0D5, 1'b1);
    send_frame(9'h12A, 1'b1);
    cycles(100);
    check("b2b_words", rx_words, 2);
    check("b2b_ov", ov_cnt, 0);
    check("b2b_fe", fe_cnt, 0);

    rx = 1'b0;
    cycles(20);
    rx = 1'b1;
    cycles(200);
    check("glitch_words", rx_words, 2);
    check("glitch_fe", fe_cnt, 0);
    check("glitch_ov", ov_cnt, 0);

    send_frame(9'h1FF, 1'b0);
    rx = 1'b0;
    cycles(500);
    rx = 1'b1;
    cycles(100);
    check("break_fe", fe_cnt, 1);
    check("break_words", rx_words, 2);
    exp_q.push_back(9'h001);
    send_frame(9'h001, 1'b1);
    cycles(100);
    check("after_break_words", rx_words, 3);
    check("after_break_fe", fe_cnt, 1);

    ready = 1'b0;
    exp_q.push_back(9'h0AA);
    send_frame(9'h0AA, 1'b1);
    send_frame(9'h155, 1'b1);
    cycles(100);
    check("ovr_pulses", ov_cnt, 1);
    check("ovr_valid", int'(valid), 1);
    check("ovr_data", int'(data), 'h0AA);
    check("ovr_words", rx_words, 3);
    ready = 1'b1;
    cycles(3);
    check("drain_words", rx_words, 4);
    check("drain_valid", int'(valid), 0);

    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    cycles(BIT / 2);
    reset = 1'b1;
    rx    = 1'b1;
    cycles(3);
    reset = 1'b0;
    check("midreset_valid", int'(valid), 0);
    check("midreset_data", int'(data), 'h000);
    cycles(100);
    exp_q.push_back(9'h100);
    send_frame(9'h100, 1'b1);
    cycles(100);
    check("midreset_words", rx_words, 5);
    check("midreset_fe", fe_cnt, 1);
    check("midreset_ov", ov_cnt, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
